// File: rtl/audio_level_meter_if.sv
// ----------------------------------------------------------------------------
// audio_level_meter_if
//
// Bundles the sample stream and the meter outputs of audio_level_meter so that
// the meter core and whatever feeds it (audio codec glue or a testbench) share
// one port list.
//
// Handshake: sample_valid is a single-cycle strobe. All NUM_CH channels in
// sample_data are valid together while it is high. There is no ready; the
// meter accepts a frame every cycle and never stalls the source.
//
// Signals (direction as seen by the meter, modport slave):
//   sample_valid in   frame strobe
//   sample_data  in   NUM_CH packed signed samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   ch_sel       in   channel shown on led_out (out-of-range selects channel 0)
//   clip_clr     in   clears sticky clip flags (clip build only)
//   level_idx    out  per-channel bar level, 4 bits each
//   peak_idx     out  per-channel held peak, 4 bits each
//   led_out      out  thermometer plus peak dot for the selected channel
//   clip_flag    out  sticky per-channel clip indication
//   level_upd    out  one-cycle pulse when level_idx/peak_idx take a new frame
//   dbg_state    out  per-channel peak FSM state, 2 bits each (0 idle, 1 hold, 2 decay)
// ----------------------------------------------------------------------------
interface audio_level_meter_if #(
  parameter int SAMPLE_W = 32,
  parameter int NUM_CH   = 2,
  parameter int NUM_SEG  = 10,
  parameter int SEL_W    = 1
);
  logic                       sample_valid;
  logic [NUM_CH*SAMPLE_W-1:0] sample_data;
  logic [SEL_W-1:0]           ch_sel;
  logic                       clip_clr;
  logic [NUM_CH*4-1:0]        level_idx;
  logic [NUM_CH*4-1:0]        peak_idx;
  logic [NUM_SEG-1:0]         led_out;
  logic [NUM_CH-1:0]          clip_flag;
  logic                       level_upd;
  logic [NUM_CH*2-1:0]        dbg_state;

  // Source side: produces samples, consumes meter results.
  modport master (
    output sample_valid, sample_data, ch_sel, clip_clr,
    input  level_idx, peak_idx, led_out, clip_flag, level_upd, dbg_state
  );

  // Meter side.
  modport slave (
    input  sample_valid, sample_data, ch_sel, clip_clr,
    output level_idx, peak_idx, led_out, clip_flag, level_upd, dbg_state
  );
endinterface

// File: rtl/audio_level_meter.sv
// ----------------------------------------------------------------------------
// audio_level_meter
//
// Multi-channel peak level meter. Signed PCM frames arrive on a one-cycle
// valid strobe; each channel is turned into a log-spaced bar level (one segment
// per STEP_SHIFT bits of magnitude) with a peak marker that is held for
// HOLD_TICKS meter ticks and then falls one segment every DECAY_TICKS ticks.
//
// Pipeline:
//   stage 1  |x| with the most negative code saturated, captured on sample_valid
//   stage 2  count of thresholds met -> level_idx, peak FSM update, level_upd
//   Latency is two clocks from sample_valid to level_idx/level_upd; a new frame
//   can enter every cycle.
//
// Ports:
//   CLOCK_50  system clock
//   resetn    asynchronous active-low reset; every output reads 0 while low
//   bus       audio_level_meter_if.slave (samples in, levels/peaks/LEDs out)
//
// Build option:
//   AUDIO_LEVEL_METER_CLIP_LATCH_EN  when defined, a sticky per-channel clip
//   flag is built (set near full scale, cleared by clip_clr, set beats clear).
//   When undefined, clip_flag is tied low and clip_clr is ignored.
// ----------------------------------------------------------------------------
module audio_level_meter #(
  parameter int SAMPLE_W    = 32,
  parameter int NUM_CH      = 2,
  parameter int NUM_SEG     = 10,
  parameter int STEP_SHIFT  = 3,
  parameter int TICK_DIV    = 500000,
  parameter int HOLD_TICKS  = 100,
  parameter int DECAY_TICKS = 5
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  audio_level_meter_if.slave bus
);

  // Magnitude width: the sign bit is gone after |x|.
  localparam int A_W    = SAMPLE_W - 1;
  localparam int LVL_W  = 4;
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int DEC_W  = $clog2(DECAY_TICKS + 1);
  localparam int PS_W   = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } peak_state_t;

  // Segment i lights when the magnitude reaches 2^(A_W-1 - STEP_SHIFT*(NUM_SEG-1-i)).
  // The top segment sits at half scale, lower ones STEP_SHIFT bits further down.
  function automatic logic [A_W-1:0] seg_thr(input int i);
    seg_thr = A_W'(1) << (SAMPLE_W - 2 - STEP_SHIFT * (NUM_SEG - 1 - i));
  endfunction

  // --------------------------------------------------------------------------
  // Stage 1: saturating absolute value
  // --------------------------------------------------------------------------
  logic [A_W-1:0] abs_d [NUM_CH];
  logic [A_W-1:0] abs_q [NUM_CH];
  logic           s1_valid;

  always_comb begin
    logic [SAMPLE_W-1:0] sx;
    sx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sx = bus.sample_data[c*SAMPLE_W +: SAMPLE_W];
      if (!sx[SAMPLE_W-1]) begin
        abs_d[c] = sx[A_W-1:0];
      end else if (sx[A_W-1:0] == '0) begin
        // -2^(SAMPLE_W-1) has no positive twin; clamp to full scale.
        abs_d[c] = '1;
      end else begin
        abs_d[c] = A_W'(-sx);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) abs_q[c] <= '0;
    end else begin
      s1_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        for (int c = 0; c < NUM_CH; c++) abs_q[c] <= abs_d[c];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: level = number of thresholds met (unsigned compares)
  // --------------------------------------------------------------------------
  logic [LVL_W-1:0] lvl_d [NUM_CH];
  logic [LVL_W-1:0] lvl_q [NUM_CH];
  logic             upd_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lvl_d[c] = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
        if (abs_q[c] >= seg_thr(i)) lvl_d[c] = lvl_d[c] + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      upd_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) lvl_q[c] <= '0;
    end else begin
      upd_q <= s1_valid;
      if (s1_valid) begin
        for (int c = 0; c < NUM_CH; c++) lvl_q[c] <= lvl_d[c];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Meter tick prescaler, free-running from reset
  // --------------------------------------------------------------------------
  logic [PS_W-1:0] ps_q;
  logic            tick;

  assign tick = (ps_q == PS_W'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) ps_q <= '0;
    else         ps_q <= tick ? '0 : ps_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Peak FSM, one per channel
  //   A frame whose level reaches the held peak takes the peak and re-arms the
  //   hold, and in that cycle a coincident tick is dropped. A quieter frame
  //   never lowers the peak; only decay ticks do.
  // --------------------------------------------------------------------------
  peak_state_t      state_q [NUM_CH];
  peak_state_t      state_d [NUM_CH];
  logic [LVL_W-1:0] peak_q  [NUM_CH];
  logic [LVL_W-1:0] peak_d  [NUM_CH];
  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [HOLD_W-1:0] hold_d [NUM_CH];
  logic [DEC_W-1:0]  dec_q  [NUM_CH];
  logic [DEC_W-1:0]  dec_d  [NUM_CH];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        peak_q[c]  <= '0;
        hold_q[c]  <= '0;
        dec_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        peak_q[c]  <= peak_d[c];
        hold_q[c]  <= hold_d[c];
        dec_q[c]   <= dec_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      peak_d[c]  = peak_q[c];
      hold_d[c]  = hold_q[c];
      dec_d[c]   = dec_q[c];

      if (s1_valid && (lvl_d[c] >= peak_q[c])) begin
        peak_d[c] = lvl_d[c];
        // A silent frame over an empty peak leaves the channel idle.
        if (lvl_d[c] != '0) begin
          state_d[c] = ST_HOLD;
          hold_d[c]  = HOLD_W'(HOLD_TICKS);
          dec_d[c]   = '0;
        end
      end else if (tick) begin
        case (state_q[c])
          ST_HOLD: begin
            if (hold_q[c] <= HOLD_W'(1)) begin
              state_d[c] = ST_DECAY;
              hold_d[c]  = '0;
              dec_d[c]   = DEC_W'(DECAY_TICKS);
            end else begin
              hold_d[c] = hold_q[c] - 1'b1;
            end
          end
          ST_DECAY: begin
            if (dec_q[c] <= DEC_W'(1)) begin
              peak_d[c] = (peak_q[c] != '0) ? peak_q[c] - 1'b1 : '0;
              dec_d[c]  = DEC_W'(DECAY_TICKS);
              if (peak_q[c] <= LVL_W'(1)) begin
                state_d[c] = ST_IDLE;
                dec_d[c]   = '0;
              end
            end else begin
              dec_d[c] = dec_q[c] - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Clip latch (optional)
  // --------------------------------------------------------------------------
`ifdef AUDIO_LEVEL_METER_CLIP_LATCH_EN
  // 2^(SAMPLE_W-1) - 2^(SAMPLE_W-7): about 0.14 dB below full scale.
  localparam logic [A_W-1:0] CLIP_T = ~((A_W'(1) << (SAMPLE_W - 7)) - A_W'(1));

  logic [NUM_CH-1:0] clip_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clip_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // Set is checked first so a clear in the same cycle cannot hide a clip.
        if (s1_valid && (abs_q[c] >= CLIP_T)) clip_q[c] <= 1'b1;
        else if (bus.clip_clr)                clip_q[c] <= 1'b0;
      end
    end
  end

  assign bus.clip_flag = clip_q;
`else
  logic unused_clip_clr;
  assign unused_clip_clr = bus.clip_clr;
  assign bus.clip_flag   = '0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.level_idx = '0;
    bus.peak_idx  = '0;
    bus.dbg_state = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.level_idx[c*LVL_W +: LVL_W] = lvl_q[c];
      bus.peak_idx[c*LVL_W +: LVL_W]  = peak_q[c];
      bus.dbg_state[c*2 +: 2]         = state_q[c];
    end
  end

  assign bus.level_upd = upd_q;

  // LED bar for the selected channel: segments below the level plus a single
  // dot at the held peak. ch_sel is used combinationally.
  logic [SEL_W-1:0] sel;
  logic [LVL_W-1:0] l_sel;
  logic [LVL_W-1:0] p_sel;

  always_comb begin
    sel = '0;
    if (int'(bus.ch_sel) < NUM_CH) sel = bus.ch_sel;
    l_sel = lvl_q[sel];
    p_sel = peak_q[sel];
    bus.led_out = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      bus.led_out[i] = (i < int'(l_sel)) ||
                       ((p_sel != '0) && (i == int'(p_sel) - 1));
    end
  end

endmodule
